// File: rtl/min_query_sched.sv
// Round-robin query scheduler with a tag pipeline that matches min results.
// Define MIN_QUERY_SCHED_STATS_EN to build the issue/conflict counters.
module min_query_sched #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 22,
  parameter int CNT_SIZE  = 32,
  parameter int PIPE_LAT  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush_req,
  output logic                          flush_done,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]  req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          issue_valid,
  output logic [ADDR_SIZE-1:0]          issue_addr,
  output logic                          query_rst_n,
  input  logic                          min_valid,
  input  logic [ADDR_SIZE-1:0]          min_addr,
  input  logic [CNT_SIZE-1:0]           min_cnt,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [ADDR_SIZE-1:0]          resp_addr,
  output logic [CNT_SIZE-1:0]           resp_cnt,
  output logic                          busy,
  output logic                          err,
  output logic [31:0]                   stat_issued,
  output logic [31:0]                   stat_conflict
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FW = $clog2(PIPE_LAT + 1) + 1;
  localparam int L  = PIPE_LAT - 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        ptr, gnt_idx, issue_idx;
  logic                 gnt_any, hs, flush_go, fl_last;
  logic                 chk_en, hit, err_ev;
  logic [FW-1:0]        fl_cnt;
  logic [ADDR_SIZE-1:0] gnt_addr;
  logic [PIPE_LAT-1:0]  tag_v;
  logic [IW-1:0]        tag_idx  [PIPE_LAT];
  logic [ADDR_SIZE-1:0] tag_addr [PIPE_LAT];

  assign flush_go    = flush_req && (state != FLUSH);
  assign fl_last     = (state == FLUSH) && (fl_cnt == FW'(PIPE_LAT));
  assign query_rst_n = (state != FLUSH);
  assign busy        = (state == FLUSH) | issue_valid | (|tag_v);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      FLUSH:   if (fl_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_go) state_nxt = FLUSH;
  end

  // first valid requester at or after ptr, wrapping
  always_comb begin
    int j;
    j         = 0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    if (state == RUN && !flush_req && gnt_any)
      req_ready[gnt_idx] = 1'b1;
  end

  assign hs       = |(req_valid & req_ready);
  assign gnt_addr = req_addr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];

  // results landing while a flush starts or runs are dropped silently
  assign chk_en = (state != FLUSH) && !flush_req;
  assign hit    = min_valid && tag_v[L] && (min_addr == tag_addr[L]);
  assign err_ev = (min_valid != tag_v[L]) ||
                  (min_valid && tag_v[L] && (min_addr != tag_addr[L]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      fl_cnt      <= '0;
      flush_done  <= 1'b0;
      issue_valid <= 1'b0;
      issue_addr  <= '0;
      issue_idx   <= '0;
      tag_v       <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_idx[i]  <= '0;
        tag_addr[i] <= '0;
      end
      resp_valid  <= '0;
      resp_addr   <= '0;
      resp_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= fl_last;
      fl_cnt     <= (state == FLUSH) ? fl_cnt + 1'b1 : '0;
      if (hs)
        ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      issue_valid <= hs;
      issue_addr  <= hs ? gnt_addr : '0;
      issue_idx   <= hs ? gnt_idx : '0;
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        tag_v[i]    <= tag_v[i-1];
        tag_idx[i]  <= tag_idx[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
      tag_v[0]    <= issue_valid;
      tag_idx[0]  <= issue_idx;
      tag_addr[0] <= issue_addr;
      if (flush_go || state == FLUSH) tag_v <= '0;
      resp_valid <= '0;
      resp_addr  <= '0;
      resp_cnt   <= '0;
      if (chk_en && hit) begin
        resp_valid[tag_idx[L]] <= 1'b1;
        resp_addr              <= min_addr;
        resp_cnt               <= min_cnt;
      end
      if (chk_en && err_ev) err <= 1'b1;
    end
  end

`ifdef MIN_QUERY_SCHED_STATS_EN
  logic [31:0] n_iss, n_cfl;

  always_ff @(posedge clk) begin
    if (rst || flush_go) begin
      n_iss <= '0;
      n_cfl <= '0;
    end else begin
      if (hs && n_iss != '1) n_iss <= n_iss + 1'b1;
      if (state == RUN && $countones(req_valid) > 1 && n_cfl != '1)
        n_cfl <= n_cfl + 1'b1;
    end
  end

  assign stat_issued   = n_iss;
  assign stat_conflict = n_cfl;
`else
  assign stat_issued   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_min_query_sched.sv
// Directed bench for min_query_sched with a delay-line min pipeline model
// and a response scoreboard queue.
module tb_min_query_sched;
  localparam int NR = 4;
  localparam int AW = 22;
  localparam int CW = 32;
  localparam int PL = 3;

  logic          clk = 1'b0;
  logic          rst, enable, flush_req, flush_done;
  logic [NR-1:0] req_valid, req_ready, resp_valid;
  logic [NR*AW-1:0] req_addr;
  logic          issue_valid, query_rst_n, min_valid, busy, err;
  logic [AW-1:0] issue_addr, min_addr, resp_addr;
  logic [CW-1:0] min_cnt, resp_cnt;
  logic [31:0]   stat_issued, stat_conflict;

  logic [AW-1:0] ra [NR];
  logic          md_v [PL];
  logic [AW-1:0] md_a [PL];
  logic          inj;
  logic [AW-1:0] inj_addr;

  typedef struct {
    logic [NR-1:0] v;
    logic [AW-1:0] a;
    logic [CW-1:0] c;
    int            due;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int fd_seen = 0;
  int stat_exp;

  min_query_sched #(
    .NUM_REQ(NR), .ADDR_SIZE(AW), .CNT_SIZE(CW), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush_req(flush_req),
    .flush_done(flush_done), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .query_rst_n(query_rst_n),
    .min_valid(min_valid), .min_addr(min_addr), .min_cnt(min_cnt),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_cnt(resp_cnt),
    .busy(busy), .err(err), .stat_issued(stat_issued),
    .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt_of(input logic [AW-1:0] a);
    return (a == 22'h00ABC) ? 32'd7 : {10'd0, a} + 32'd1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [NR-1:0] g);
    logic [AW-1:0] r;
    r = '0;
    for (int k = 0; k < NR; k++) if (g[k]) r = ra[k];
    return r;
  endfunction

  // downstream lookup model: result PL cycles after each issue
  always @(posedge clk) begin
    for (int k = PL - 1; k > 0; k--) begin
      md_v[k] <= md_v[k-1];
      md_a[k] <= md_a[k-1];
    end
    md_v[0] <= issue_valid;
    md_a[0] <= issue_addr;
  end

  assign min_valid = inj | md_v[PL-1];
  assign min_addr  = inj ? inj_addr : md_a[PL-1];
  assign min_cnt   = cnt_of(min_addr);
  assign req_addr  = {ra[3], ra[2], ra[1], ra[0]};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (flush_done === 1'b1) fd_seen++;
    if (resp_valid !== '0) begin
      if (q.size() == 0) begin
        chk("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'(e.v));
        chk("resp_addr", 64'(resp_addr), 64'(e.a));
        chk("resp_cnt", 64'(resp_cnt), 64'(e.c));
        chk("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      chk("resp_missing", 64'(resp_valid), 64'(q[0].v));
      void'(q.pop_front());
    end
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] g,
                       input bit want_resp);
    exp_t e;
    req_valid = v;
    #1;
    chk("req_ready", 64'(req_ready), 64'(g));
    if (g != '0 && want_resp) begin
      e.v = g;
      e.a = addr_of(g);
      e.c = cnt_of(addr_of(g));
      e.due = cyc + PL + 2;
      q.push_back(e);
    end
    tick();
    chk("issue_valid", 64'(issue_valid), 64'(g != '0));
    chk("issue_addr", 64'(issue_addr), 64'(addr_of(g)));
  endtask

  initial begin
    ra[0] = 22'h00ABC;
    ra[1] = 22'h01234;
    ra[2] = 22'h2F00D;
    ra[3] = 22'h3FFFF;
    for (int k = 0; k < PL; k++) begin
      md_v[k] = 1'b0;
      md_a[k] = '0;
    end
    inj = 1'b0; inj_addr = '0;
    rst = 1'b1; enable = 1'b0; flush_req = 1'b0; req_valid = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset values
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_qrst_n", 64'(query_rst_n), 64'd1);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_stat_issued", 64'(stat_issued), 64'd0);

    // fairness: all four requesting for eight RUN cycles
    enable = 1'b1;
    drive(4'b1111, 4'b0000, 0);
    for (int i = 0; i < 8; i++) drive(4'b1111, 4'(1 << (i % 4)), 1);
    chk("busy_inflight", 64'(busy), 64'd1);
    req_valid = '0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("fair_drained", 64'(q.size()), 64'd0);
`ifdef MIN_QUERY_SCHED_STATS_EN
    stat_exp = 8;
`else
    stat_exp = 0;
`endif
    chk("stat_conflict", 64'(stat_conflict), 64'(stat_exp));
    chk("stat_issued", 64'(stat_issued), 64'(stat_exp));

    // single query from requester 0
    drive(4'b0001, 4'b0001, 1);
    req_valid = '0;
    for (int i = 0; i < 8 && q.size() != 0; i++) tick();
    chk("single_drained", 64'(q.size()), 64'd0);
    chk("single_err", 64'(err), 64'd0);

    // flush with three queries in flight; same-cycle grant suppressed
    drive(4'b0001, 4'b0001, 0);
    drive(4'b0010, 4'b0010, 0);
    drive(4'b0100, 4'b0100, 0);
    flush_req = 1'b1;
    drive(4'b1000, 4'b0000, 0);
    flush_req = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < PL + 1; i++) begin
      chk("flush_qrst_n", 64'(query_rst_n), 64'd0);
      chk("flush_ready", 64'(req_ready), 64'd0);
      chk("flush_busy", 64'(busy), 64'd1);
      chk("flush_done_early", 64'(flush_done), 64'd0);
      if (i == 1) flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
    end
    chk("flush_done", 64'(flush_done), 64'd1);
    chk("flush_qrst_back", 64'(query_rst_n), 64'd1);
    chk("flush_idle_ready", 64'(req_ready), 64'd0);
    chk("flush_err", 64'(err), 64'd0);
    chk("flush_stat", 64'(stat_issued), 64'd0);
    enable = 1'b0;
    req_valid = '0;
    tick();
    chk("flush_done_pulse", 64'(flush_done), 64'd0);
    chk("flush_busy_end", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("flush_no_resp", 64'(q.size()), 64'd0);

    // orphan min result sets the sticky error
    inj = 1'b1;
    inj_addr = 22'h00005;
    tick();
    inj = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("err_sticky", 64'(err), 64'd1);

    // reset on the second flush cycle
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    chk("mid_flush_qrst", 64'(query_rst_n), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_qrst_n", 64'(query_rst_n), 64'd1);
    chk("mrst_issue", 64'(issue_valid), 64'd0);
    chk("mrst_resp", 64'(resp_valid), 64'd0);
    fd_seen = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("mrst_no_flush_done", 64'(fd_seen), 64'd0);
    chk("mrst_qrst_hold", 64'(query_rst_n), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
